// File: rtl/uart_loopback_unit.sv
// uart_loopback_unit: 8N1 UART transmitter whose serial output feeds an 8N1
// UART receiver through a 2-flop synchronizer, exported on tx for observation.
// Optional macro UART_PARITY_EN adds an even-parity bit between D7 and the stop
// bit, a receive-side parity check and a parity_err pulse output.
// Handshake: tx_start is a one-cycle request, accepted only while the TX FSM is
// idle (no ready output, requests during a frame are dropped); rx_done is a
// one-cycle valid strobe qualifying rx_data, with no backpressure.
`timescale 1ns/1ps

module uart_loopback_unit #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_done
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_RECOVER
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_n;

    // TX next-state: walk the frame one bit-time at a time; tx is registered
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        case (tx_state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (tx_start) begin
                    tx_shift_n = tx_data;
                    tx_n       = 1'b0;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    tx_n       = tx_shift[0];
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_n       = ^tx_shift;
                        tx_state_n = TX_PARITY;
`else
                        tx_n       = 1'b1;
                        tx_state_n = TX_STOP;
`endif
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        tx_n     = tx_shift[tx_bit + 3'd1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_n       = 1'b1;
                    tx_state_n = TX_STOP;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_n       = 1'b1;
                tx_cnt_n   = '0;
                tx_state_n = TX_IDLE;
            end
        endcase
    end

    // TX state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // ---------------- receiver ----------------
    logic sync_1, sync_2;

    // Two-flop synchronizer on the looped-back line, idling high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= tx;
            sync_2 <= sync_1;
        end
    end

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [7:0]    rx_data_n;
    logic          rx_done_n;
`ifdef UART_PARITY_EN
    logic          rx_perr, rx_perr_n;
    logic          parity_err_n;
`endif

    // RX next-state: align to mid-start, then sample every bit at its midpoint
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_done_n  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_n    = rx_perr;
        parity_err_n = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!sync_2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = 3'd0;
                    // a line back high at mid-start was only a glitch
                    rx_state_n = sync_2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {sync_2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
`ifdef UART_PARITY_EN
                    rx_perr_n  = sync_2 ^ (^rx_shift);
`endif
                    rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (sync_2) begin
`ifdef UART_PARITY_EN
                        if (rx_perr) begin
                            parity_err_n = 1'b1;
                        end else begin
                            rx_data_n = rx_shift;
                            rx_done_n = 1'b1;
                        end
`else
                        rx_data_n = rx_shift;
                        rx_done_n = 1'b1;
`endif
                        rx_state_n = RX_IDLE;
                    end else begin
                        // framing error: drop the byte, wait for an idle line
                        rx_state_n = RX_RECOVER;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_RECOVER: begin
                if (sync_2) rx_state_n = RX_IDLE;
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // RX state, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_done  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            rx_done  <= rx_done_n;
`ifdef UART_PARITY_EN
            rx_perr    <= rx_perr_n;
            parity_err <= parity_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_loopback_unit.sv
// tb_uart_loopback_unit: frame-timeline model of the serial line plus a byte
// scoreboard for the receive side, checked on every falling clock edge.
`timescale 1ns/1ps

module tb_uart_loopback_unit;

    localparam int CPB = 50000000 / 115200;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;
    // rx_done is due half a bit into the stop bit, plus synchronizer/FSM lag
    localparam int DONE_MIN  = (FB - 1) * CPB + CPB / 2;
    localparam int DONE_MAX  = DONE_MIN + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic [7:0] rx_data;
    logic       rx_done;
`ifdef UART_PARITY_EN
    logic       parity_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    uart_loopback_unit #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
        .clk(clk),
        .rst(rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx(tx),
        .rx_data(rx_data),
        .rx_done(rx_done)
`ifdef UART_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // ---------------- clock ----------------
    initial forever #10 clk = ~clk;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    logic       m_busy = 1'b0;
    int         m_k = 0;
    logic       m_frame [FB];
    logic [7:0] m_last = 8'h00;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [7:0] b);
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[i + 1] = b[i];
`ifdef UART_PARITY_EN
        m_frame[9] = ^b;
`endif
        m_frame[FB - 1] = 1'b1;
    endfunction

    // Timeline: an accepted byte occupies the line for FB*CPB cycles
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_last = 8'h00;
            exp_q.delete();
        end else if (m_busy) begin
            if (m_k == FRAME_CYC - 1) m_busy = 1'b0;
            else m_k++;
        end else if (tx_start) begin
            build_frame(tx_data);
            exp_q.push_back(tx_data);
            m_busy = 1'b1;
            m_k    = 0;
        end
    end

    // ---------------- compare ----------------
    initial begin
        logic prev_busy;
        logic [7:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("tx_line", {31'd0, tx}, m_busy ? {31'd0, m_frame[m_k / CPB]} : 32'd1);
                if (rx_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rx_done_spurious: got pulse expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, rx_data}, {24'd0, e});
                        m_last = e;
                        check("rx_done_time", {31'd0, (m_busy && m_k >= DONE_MIN && m_k <= DONE_MAX)}, 32'd1);
                    end
                end
                check("rx_data_hold", {24'd0, rx_data}, {24'd0, m_last});
`ifdef UART_PARITY_EN
                check("parity_err", {31'd0, parity_err}, 32'd0);
`endif
                if (prev_busy && !m_busy)
                    check("rx_pending", exp_q.size(), 32'd0);
            end
            prev_busy = m_busy;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        int budget;
        budget = 0;
        @(negedge clk);
        while (m_busy && budget < FRAME_CYC + 10) begin
            @(negedge clk);
            budget++;
        end
        check("idle_wait", {31'd0, m_busy}, 32'd0);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (m_busy && budget < FRAME_CYC + 10) begin
            @(negedge clk);
            budget++;
        end
        check("frame_end_wait", {31'd0, m_busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [FB-1:0] pat;
        int d0;
        logic [7:0] b;

        // reset
        #100;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_no_done", done_cnt, 32'd0);

        // single byte 0x41 with a busy-time request for 0xFF
`ifdef UART_PARITY_EN
        pat = 11'b10010000010;
`else
        pat = 10'b1010000010;
`endif
        send(8'h41);
        repeat (CPB / 2) @(negedge clk);
        check("bit_0", {31'd0, tx}, {31'd0, pat[0]});
        for (int i = 1; i < FB; i++) begin
            if (i == 4) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (CPB - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
            check($sformatf("bit_%0d", i), {31'd0, tx}, {31'd0, pat[i]});
        end
        wait_done();
        repeat (CPB) @(negedge clk);
        check("single_done_cnt", done_cnt, 32'd1);
        check("single_rx_data", {24'd0, rx_data}, 32'h41);

        // back-to-back
        d0 = done_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        wait_done();
        check("b2b_done_cnt", done_cnt - d0, 32'd3);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hA5);

        // reset during data bit 3 of 0x55
        send(8'h55);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_rx_done", {31'd0, rx_done}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (FRAME_CYC / 2) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        send(8'h3C);
        wait_done();
        check("after_rst_rx_data", {24'd0, rx_data}, 32'h3C);

`ifdef UART_PARITY_EN
        send(8'h07);
        repeat (9 * CPB + CPB / 2) @(negedge clk);
        check("parity_bit_07", {31'd0, tx}, 32'd1);
        wait_done();
        check("parity_rx_data", {24'd0, rx_data}, 32'h07);
`endif

        // randomized frames with stray requests during busy
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(3, 3000)) @(negedge clk);
                tx_data  = 8'($urandom);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        end
        wait_done();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
